axis_xform_decoder: RTL and testbench

Receive-side inverse of the stream transform block: accepts an AXI-Stream carrying transformed beats (pass-through, byte-reversed, or constant-added) and restores the original data. Sits at the far end of the link, downstream of the transform block, with matching `mode`/`constant_value` control. Uses a 2-entry skid buffer for full throughput under backpressure. Latches the mode per packet and exposes beat/packet counters plus a sticky null-TKEEP error.

---
 rtl/axis_xform_decoder.sv | 138 +++++++++++++
 tb/tb_axis_xform_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_xform_decoder.sv
// Inverse of the stream transform: undoes pass/byte-reverse/constant-add per packet
// and buffers results in a 2-entry skid buffer, with beat/packet counters and a keep error flag.
module axis_xform_decoder #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic [1:0]                 mode,
  input  logic [TDATA_WIDTH-1:0]     constant_value,
  output logic [31:0]                beat_count,
  output logic [31:0]                pkt_count,
  output logic                       keep_err
);
  localparam int KW = TDATA_WIDTH / 8;

  // Handshake: a beat moves on an edge where valid && ready; valid never waits on ready,
  // and a presented output beat holds its payload until it is taken.
  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t                 state;
  logic [1:0]             act_mode;
  logic [TDATA_WIDTH-1:0] act_const;

  logic                   main_valid;
  logic [TDATA_WIDTH-1:0] main_data;
  logic [KW-1:0]          main_keep;
  logic                   main_last;
  logic                   skid_valid;
  logic [TDATA_WIDTH-1:0] skid_data;
  logic [KW-1:0]          skid_keep;
  logic                   skid_last;
  logic                   ready_r;

  logic                   accept;
  logic                   drain;
  logic                   skid_next;
  logic [1:0]             eff_mode;
  logic [TDATA_WIDTH-1:0] eff_const;
  logic [TDATA_WIDTH-1:0] dec_data;
  logic [KW-1:0]          dec_keep;

  assign s_axis_tready = ready_r;
  assign m_axis_tvalid = main_valid;
  assign m_axis_tdata  = main_data;
  assign m_axis_tkeep  = main_keep;
  assign m_axis_tlast  = main_last;

  always_comb begin
    accept    = s_axis_tvalid && ready_r;
    drain     = main_valid && m_axis_tready;
    // Skid only fills when main is stalled; it empties whenever main drains.
    skid_next = skid_valid ? !drain : (accept && main_valid && !drain);
    // The first beat of a packet decodes with the live controls it is about to latch.
    eff_mode  = (state == IDLE) ? mode : act_mode;
    eff_const = (state == IDLE) ? constant_value : act_const;
    dec_data  = s_axis_tdata;
    dec_keep  = s_axis_tkeep;
    case (eff_mode)
      2'd1: begin
        for (int i = 0; i < KW; i++) begin
          dec_data[8*i +: 8] = s_axis_tdata[8*(KW-1-i) +: 8];
          dec_keep[i]        = s_axis_tkeep[KW-1-i];
        end
      end
      2'd2:    dec_data = s_axis_tdata - eff_const;
      default: dec_data = s_axis_tdata;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      act_mode  <= 2'd0;
      act_const <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        act_mode  <= mode;
        act_const <= constant_value;
      end
      state <= s_axis_tlast ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_keep  <= '0;
      main_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      ready_r    <= 1'b0;
      beat_count <= 32'd0;
      pkt_count  <= 32'd0;
      keep_err   <= 1'b0;
    end else begin
      if (skid_valid) begin
        if (drain) begin
          main_data <= skid_data;
          main_keep <= skid_keep;
          main_last <= skid_last;
        end
      end else if (accept) begin
        if (!main_valid || drain) begin
          main_valid <= 1'b1;
          main_data  <= dec_data;
          main_keep  <= dec_keep;
          main_last  <= s_axis_tlast;
        end else begin
          skid_data <= dec_data;
          skid_keep <= dec_keep;
          skid_last <= s_axis_tlast;
        end
      end else if (drain) begin
        main_valid <= 1'b0;
      end
      skid_valid <= skid_next;
      ready_r    <= !skid_next;
      if (drain) begin
        beat_count <= beat_count + 32'd1;
        if (main_last) pkt_count <= pkt_count + 32'd1;
      end
      if (accept && (s_axis_tkeep == '0)) keep_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_xform_decoder.sv
// Directed and randomized checks of axis_xform_decoder against a packet-level reference model.
module tb_axis_xform_decoder;
  localparam int W  = 32;
  localparam int KW = W / 8;
  localparam int BW = W + KW + 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  constant_value = '0;
  logic [31:0]   beat_count;
  logic [31:0]   pkt_count;
  logic          keep_err;

  axis_xform_decoder #(.TDATA_WIDTH(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .mode(mode), .constant_value(constant_value),
    .beat_count(beat_count), .pkt_count(pkt_count), .keep_err(keep_err)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model state: expected output queue, packet latching, counters
  logic [BW-1:0] exp_q[$];
  bit            in_pkt = 0;
  logic [1:0]    lat_mode = 2'd0;
  logic [W-1:0]  lat_const = '0;
  logic [31:0]   exp_beats = 0;
  logic [31:0]   exp_pkts = 0;
  bit            exp_keep_err = 0;
  int            occ = 0;
  bit            prev_stall = 0;
  logic [BW-1:0] prev_beat = '0;

  function automatic logic [BW-1:0] model_decode(input logic [W-1:0] d, input logic [KW-1:0] k,
                                                 input logic l, input logic [1:0] m,
                                                 input logic [W-1:0] c);
    logic [W-1:0]  od;
    logic [KW-1:0] ok;
    od = d;
    ok = k;
    if (m == 2'd1) begin
      od = {<<8{d}};
      ok = {<<{k}};
    end else if (m == 2'd2) begin
      od = d - c;
    end
    return {od, ok, l};
  endfunction

  always @(posedge aclk) begin
    logic [BW-1:0] got;
    logic [BW-1:0] want;
    logic [1:0]    um;
    logic [W-1:0]  uc;
    if (!aresetn) begin
      exp_q.delete();
      in_pkt = 0;
      exp_beats = 0;
      exp_pkts = 0;
      exp_keep_err = 0;
      occ = 0;
      prev_stall = 0;
    end else begin
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (prev_stall) chk("hold_stable", {m_axis_tvalid, got}, {1'b1, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk("out_beat", got, want);
        exp_beats++;
        if (m_axis_tlast) exp_pkts++;
        occ--;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        um = in_pkt ? lat_mode : mode;
        uc = in_pkt ? lat_const : constant_value;
        if (!in_pkt) begin
          lat_mode = mode;
          lat_const = constant_value;
        end
        in_pkt = !s_axis_tlast;
        exp_q.push_back(model_decode(s_axis_tdata, s_axis_tkeep, s_axis_tlast, um, uc));
        if (s_axis_tkeep == '0) exp_keep_err = 1;
        occ++;
        chk("occupancy_le_2", 64'(occ <= 2), 64'd1);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = got;
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
    bit got;
    got = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      got = s_axis_tready;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!got) chk("send_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_idle();
    m_axis_tready = 1'b1;
    for (int n = 0; n < 50 && m_axis_tvalid; n++) begin
      @(posedge aclk);
      #1;
    end
    chk("drain_timeout", 64'(m_axis_tvalid), 64'd0);
  endtask

  initial begin
    int idx;
    int sent;
    bit got;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 64'd0);
    chk("rst_counts", {beat_count, pkt_count}, 64'd0);
    chk("rst_keep_err", 64'(keep_err), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_s_tready", 64'(s_axis_tready), 64'd1);

    // Mode 1 byte reverse, single-beat packet
    m_axis_tready = 1'b1;
    mode = 2'd1;
    send_beat(32'h7856_3412, 4'b0011, 1'b1);
    chk("m1_valid", 64'(m_axis_tvalid), 64'd1);
    chk("m1_data", 64'(m_axis_tdata), 64'h1234_5678);
    chk("m1_keep_last", {m_axis_tkeep, m_axis_tlast}, {4'b1100, 1'b1});
    @(posedge aclk);
    #1;
    chk("m1_pkt_count", 64'(pkt_count), 64'd1);
    chk("m1_beat_count", 64'(beat_count), 64'd1);

    // Mode 2 subtract, including borrow wrap
    mode = 2'd2;
    constant_value = 32'h5;
    send_beat(32'h1234_567D, 4'hF, 1'b1);
    chk("m2_data", 64'(m_axis_tdata), 64'h1234_5678);
    constant_value = 32'hFFFF_FFFF;
    send_beat(32'hFFFF_FFFE, 4'hF, 1'b1);
    chk("m2_wrap", 64'(m_axis_tdata), 64'hFFFF_FFFF);

    // Mode latched per packet; mid-packet control change ignored
    constant_value = 32'h10;
    send_beat(32'h1000_0100, 4'hF, 1'b0);
    chk("latch_b1", 64'(m_axis_tdata), 64'h1000_00F0);
    mode = 2'd1;
    constant_value = 32'h99;
    send_beat(32'h2000_0200, 4'hF, 1'b0);
    chk("latch_b2", 64'(m_axis_tdata), 64'h2000_01F0);
    send_beat(32'h3000_0300, 4'hF, 1'b1);
    chk("latch_b3", 64'(m_axis_tdata), 64'h3000_02F0);
    send_beat(32'hAABB_CCDD, 4'b0001, 1'b1);
    chk("next_pkt_m1", {m_axis_tdata, m_axis_tkeep}, {32'hDDCC_BBAA, 4'b1000});
    wait_idle();

    // Backpressure: 4 beats offered continuously, m_axis_tready low for 3 cycles
    mode = 2'd0;
    idx = 0;
    s_axis_tkeep = 4'hF;
    s_axis_tvalid = 1'b1;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      m_axis_tready = (cyc >= 3);
      s_axis_tdata  = 32'(idx + 1);
      s_axis_tlast  = (idx == 3);
      @(negedge aclk);
      got = s_axis_tready;
      @(posedge aclk);
      #1;
      if (got) idx++;
      if (cyc == 1) begin
        chk("bp_accepted_2", 64'(idx), 64'd2);
        chk("bp_ready_drop", 64'(s_axis_tready), 64'd0);
      end
    end
    s_axis_tvalid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    wait_idle();
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_beat_count", 64'(beat_count), 64'(exp_beats));

    // Sticky keep error
    send_beat(32'h0, 4'h0, 1'b1);
    @(posedge aclk);
    #1;
    chk("keep_err_set", 64'(keep_err), 64'd1);
    send_beat(32'h1, 4'hF, 1'b1);
    send_beat(32'h2, 4'h3, 1'b1);
    @(posedge aclk);
    #1;
    chk("keep_err_sticky", 64'(keep_err), 64'd1);

    // Reset mid-packet with both buffers occupied
    m_axis_tready = 1'b0;
    mode = 2'd2;
    constant_value = 32'h3;
    send_beat(32'h100, 4'hF, 1'b0);
    send_beat(32'h200, 4'hF, 1'b0);
    chk("pre_rst_full", {m_axis_tvalid, s_axis_tready}, {1'b1, 1'b0});
    aresetn = 1'b0;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_counts", {beat_count, pkt_count}, 64'd0);
    chk("midrst_keep_err", 64'(keep_err), 64'd0);
    aresetn = 1'b1;
    mode = 2'd0;
    @(posedge aclk);
    #1;
    chk("midrst_ready_back", 64'(s_axis_tready), 64'd1);
    m_axis_tready = 1'b1;
    send_beat(32'hCAFE_F00D, 4'hF, 1'b1);
    chk("fresh_pkt", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
        {1'b1, 32'hCAFE_F00D, 4'hF, 1'b1});
    wait_idle();

    // Randomized traffic, controls and backpressure
    sent = 0;
    s_axis_tdata = $urandom;
    s_axis_tkeep = 4'($urandom_range(0, 15));
    s_axis_tlast = ($urandom_range(0, 3) == 0);
    for (int cyc = 0; cyc < 6000 && sent < 300; cyc++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) constant_value = $urandom;
      @(negedge aclk);
      got = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (got) begin
        sent++;
        s_axis_tdata = $urandom;
        s_axis_tkeep = 4'($urandom_range(0, 15));
        s_axis_tlast = ($urandom_range(0, 3) == 0);
      end
    end
    s_axis_tvalid = 1'b0;
    chk("rand_all_sent", 64'(sent), 64'd300);
    wait_idle();
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rand_beat_count", 64'(beat_count), 64'(exp_beats));
    chk("rand_pkt_count", 64'(pkt_count), 64'(exp_pkts));
    chk("rand_keep_err", 64'(keep_err), 64'(exp_keep_err));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
